// File: rtl/dual_port_ram.sv
// Dual-port RAM: one write port and one registered read port on a shared clock.
// The memory is built from flops so an asynchronous reset can clear every word.
// Out-of-range writes are dropped. Out-of-range reads return zero.
// Configuration macro: DPRAM_WRITE_FIRST_EN
//   defined   -> a read and write to the same address on one edge return the new data
//   undefined -> a read and write to the same address on one edge return the old data
module dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_wr,
    input  logic                  en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out
);

    // Range compare uses one extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DepthW = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] d_out_d;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  same_addr;

    // Decode whether each port targets a word that actually exists.
    always_comb begin
        wr_hit    = en_wr && ({1'b0, addr_wr} < DepthW);
        rd_hit    = en_rd && ({1'b0, addr_rd} < DepthW);
        same_addr = (addr_wr == addr_rd);
    end

    // Storage words; each word loads only when the write port addresses it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[i] <= '0;
            end else if (wr_hit && (addr_wr == ADDR_WIDTH'(i))) begin
                mem_q[i] <= d_in;
            end
        end
    end

    // Read mux over the stored words. An address with no matching word yields zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (addr_rd == ADDR_WIDTH'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    // Next read data, including the same-address collision policy.
    always_comb begin
        d_out_d = '0;
        if (rd_hit) begin
`ifdef DPRAM_WRITE_FIRST_EN
            // Forward the incoming write data around the array.
            d_out_d = (wr_hit && same_addr) ? d_in : rd_word;
`else
            // The array still holds the old word on this edge.
            d_out_d = rd_word;
`endif
        end
    end

    // Registered read port; holds its value whenever the read enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= '0;
        end else if (en_rd) begin
            d_out <= d_out_d;
        end
    end

    // Enables must be known whenever the RAM is out of reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({en_wr, en_rd}))
            else $error("dual_port_ram: unknown enable");
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
// Instance a uses the default geometry. Instance b has DEPTH=3 and ADDR_WIDTH=2,
// which leaves one address out of range.
module tb_dual_port_ram;

    logic       clk;
    logic       rst_n;
    logic       en_wr;
    logic       en_rd;
    logic       addr_wr;
    logic       addr_rd;
    logic [3:0] d_in;
    logic [3:0] d_out;

    logic       b_rst_n;
    logic       b_en_wr;
    logic       b_en_rd;
    logic [1:0] b_addr_wr;
    logic [1:0] b_addr_rd;
    logic [3:0] b_d_in;
    logic [3:0] b_d_out;

    int tests_run;
    int tests_failed;

    dual_port_ram #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(1),
        .DEPTH     (2)
    ) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_wr  (en_wr),
        .en_rd  (en_rd),
        .addr_wr(addr_wr),
        .addr_rd(addr_rd),
        .d_in   (d_in),
        .d_out  (d_out)
    );

    dual_port_ram #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(2),
        .DEPTH     (3)
    ) u_dut_b (
        .clk    (clk),
        .rst_n  (b_rst_n),
        .en_wr  (b_en_wr),
        .en_rd  (b_en_rd),
        .addr_wr(b_addr_wr),
        .addr_rd(b_addr_rd),
        .d_in   (b_d_in),
        .d_out  (b_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        en_rd   = 1'b1;
        addr_rd = 1'b0;
        en_wr   = 1'b1;
        addr_wr = 1'b0;
        d_in    = 4'hF;
        #2;
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_async: d_out=%0h expected=0", d_out);
        end
        tick();
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: d_out=%0h expected=0", d_out);
        end
        #3 rst_n = 1'b1;
        en_wr = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_read0: d_out=%0h expected=0", d_out);
        end
        addr_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_read1: d_out=%0h expected=0", d_out);
        end
        en_rd = 1'b0;
    endtask

    task automatic test_write_read();
        en_wr   = 1'b1;
        addr_wr = 1'b1;
        d_in    = 4'd3;
        tick();
        addr_wr = 1'b0;
        d_in    = 4'd6;
        tick();
        en_wr   = 1'b0;
        en_rd   = 1'b1;
        addr_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'd3) begin
            tests_failed++;
            $display("FAIL write_read_addr1: d_out=%0h expected=3", d_out);
        end
        addr_rd = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd6) begin
            tests_failed++;
            $display("FAIL write_read_addr0: d_out=%0h expected=6", d_out);
        end
    endtask

    task automatic test_hold();
        en_rd   = 1'b0;
        en_wr   = 1'b1;
        addr_wr = 1'b0;
        d_in    = 4'd9;
        tick();
        tests_run++;
        if (d_out !== 4'd6) begin
            tests_failed++;
            $display("FAIL hold_during_write: d_out=%0h expected=6", d_out);
        end
        en_wr = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd6) begin
            tests_failed++;
            $display("FAIL hold_idle: d_out=%0h expected=6", d_out);
        end
        en_rd   = 1'b1;
        addr_rd = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd9) begin
            tests_failed++;
            $display("FAIL hold_next_read: d_out=%0h expected=9", d_out);
        end
    endtask

    task automatic test_collision();
        logic [3:0] exp_coll;
`ifdef DPRAM_WRITE_FIRST_EN
        exp_coll = 4'd5;
`else
        exp_coll = 4'd3;
`endif
        // mem[1] holds 3 from test_write_read.
        en_wr   = 1'b1;
        addr_wr = 1'b1;
        d_in    = 4'd5;
        en_rd   = 1'b1;
        addr_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== exp_coll) begin
            tests_failed++;
            $display("FAIL collision_same_edge: d_out=%0h expected=%0h", d_out, exp_coll);
        end
        en_wr = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd5) begin
            tests_failed++;
            $display("FAIL collision_next_read: d_out=%0h expected=5", d_out);
        end
        // Different addresses on one edge must not interact.
        en_wr   = 1'b1;
        addr_wr = 1'b0;
        d_in    = 4'hA;
        addr_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'd5) begin
            tests_failed++;
            $display("FAIL diff_addr_read: d_out=%0h expected=5", d_out);
        end
        en_wr   = 1'b0;
        addr_rd = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'hA) begin
            tests_failed++;
            $display("FAIL diff_addr_write: d_out=%0h expected=a", d_out);
        end
    endtask

    task automatic test_idle();
        // d_out=A, mem[0]=A, mem[1]=5. Toggle data/addresses with both enables low.
        en_wr   = 1'b0;
        en_rd   = 1'b0;
        addr_wr = 1'b1;
        addr_rd = 1'b1;
        d_in    = 4'h2;
        tick();
        tick();
        tests_run++;
        if (d_out !== 4'hA) begin
            tests_failed++;
            $display("FAIL idle_hold: d_out=%0h expected=a", d_out);
        end
        en_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'd5) begin
            tests_failed++;
            $display("FAIL idle_mem_unchanged: d_out=%0h expected=5", d_out);
        end
    endtask

    task automatic test_async_reset();
        en_wr   = 1'b1;
        addr_wr = 1'b0;
        d_in    = 4'd6;
        en_rd   = 1'b0;
        tick();
        en_wr   = 1'b0;
        en_rd   = 1'b1;
        addr_rd = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd6) begin
            tests_failed++;
            $display("FAIL async_pre: d_out=%0h expected=6", d_out);
        end
        en_rd = 1'b0;
        #2 rst_n = 1'b0;
        en_wr   = 1'b1;
        addr_wr = 1'b1;
        d_in    = 4'hC;
        #1;
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_immediate: d_out=%0h expected=0", d_out);
        end
        tick();
        #3 rst_n = 1'b1;
        en_wr = 1'b0;
        en_rd = 1'b1;
        addr_rd = 1'b0;
        tick();
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_read0: d_out=%0h expected=0", d_out);
        end
        addr_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_read1: d_out=%0h expected=0", d_out);
        end
        // First edge after release operates normally.
        en_rd   = 1'b0;
        en_wr   = 1'b1;
        addr_wr = 1'b1;
        d_in    = 4'h7;
        tick();
        en_wr = 1'b0;
        en_rd = 1'b1;
        tick();
        tests_run++;
        if (d_out !== 4'h7) begin
            tests_failed++;
            $display("FAIL async_post_write: d_out=%0h expected=7", d_out);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0] exp_words [3];
        exp_words[0] = 4'd1;
        exp_words[1] = 4'd2;
        exp_words[2] = 4'd4;
        b_en_rd = 1'b0;
        b_en_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_addr_wr = 2'(i);
            b_d_in    = exp_words[i];
            tick();
        end
        b_addr_wr = 2'd3;
        b_d_in    = 4'd7;
        tick();
        b_en_wr   = 1'b0;
        b_en_rd   = 1'b1;
        b_addr_rd = 2'd2;
        tick();
        b_addr_rd = 2'd3;
        tick();
        tests_run++;
        if (b_d_out !== 4'd0) begin
            tests_failed++;
            $display("FAIL oor_read3: d_out=%0h expected=0", b_d_out);
        end
        for (int i = 0; i < 3; i++) begin
            b_addr_rd = 2'(i);
            tick();
            tests_run++;
            if (b_d_out !== exp_words[i]) begin
                tests_failed++;
                $display("FAIL oor_word%0d: d_out=%0h expected=%0h", i, b_d_out, exp_words[i]);
            end
        end
        b_en_rd = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        en_wr     = 1'b0;
        en_rd     = 1'b0;
        addr_wr   = 1'b0;
        addr_rd   = 1'b0;
        d_in      = 4'd0;
        b_rst_n   = 1'b0;
        b_en_wr   = 1'b0;
        b_en_rd   = 1'b0;
        b_addr_wr = 2'd0;
        b_addr_rd = 2'd0;
        b_d_in    = 4'd0;
        #12 b_rst_n = 1'b1;

        test_reset();
        test_write_read();
        test_hold();
        test_collision();
        test_idle();
        test_async_reset();
        test_out_of_range();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 4, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 1, address width of both ports.
REQ-003 Parameter DEPTH, default 2, number of words; legal range 1 to 2**ADDR_WIDTH.
REQ-004 CLK  input  1  single clock; all sampling on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 EN_WR  input  1  write enable.
REQ-007 EN_RD  input  1  read enable.
REQ-008 ADDR_WR  input  ADDR_WIDTH  write address.
REQ-009 ADDR_RD  input  ADDR_WIDTH  read address.
REQ-010 D_IN  input  DATA_WIDTH  write data.
REQ-011 D_OUT  output  DATA_WIDTH  registered read data.

Function
REQ-012 Storage SHALL be DEPTH words of DATA_WIDTH bits; write and read ports are independent and may be used in the same cycle.
REQ-013 On a rising CLK edge with EN_WR=1 and ADDR_WR<DEPTH, mem[ADDR_WR] SHALL take D_IN.
REQ-014 On a rising CLK edge with EN_RD=1 and ADDR_RD<DEPTH, D_OUT SHALL take mem[ADDR_RD]; read latency is exactly one clock edge.
REQ-015 With EN_RD=0, D_OUT SHALL hold its previous value.
REQ-016 Writes with ADDR_WR>=DEPTH SHALL be ignored; memory is unchanged.
REQ-017 Reads with EN_RD=1 and ADDR_RD>=DEPTH SHALL load D_OUT with all zeros.
REQ-018 Same-edge read and write to the same address SHALL follow REQ-028/REQ-029; different addresses SHALL not interact.
REQ-019 Address arithmetic is the caller's concern; address inputs are used modulo 2**ADDR_WIDTH as presented (no internal wrap logic).
REQ-020 With EN_WR=0 and EN_RD=0, no state SHALL change.
REQ-021 X or undriven enables are illegal; behaviour is undefined.

Reset
REQ-022 RST_N low SHALL immediately, independent of CLK, clear D_OUT to 0.
REQ-023 RST_N low SHALL clear every memory word to 0.
REQ-024 While RST_N is low, writes and reads SHALL be ignored.
REQ-025 The first active edge after RST_N deasserts SHALL operate normally.
REQ-026 Reset asserted mid-operation SHALL discard any write on that edge; no partial update.

Configuration
REQ-027 Macro DPRAM_WRITE_FIRST_EN selects same-address read-during-write behaviour.
REQ-028 With DPRAM_WRITE_FIRST_EN defined, a same-edge read and write to the same valid address SHALL load D_OUT with D_IN (write-first bypass).
REQ-029 With DPRAM_WRITE_FIRST_EN undefined, a same-edge read and write to the same valid address SHALL load D_OUT with the old mem contents (read-first); the new data is visible on the next read.

Verification
REQ-030 Reset: drive RST_N=0 with EN_RD=1 -> D_OUT=0; after release, read addr 0 and addr 1 -> D_OUT=0 for both.
REQ-031 Write then read: write addr1=3, addr0=6 on consecutive edges; read addr1, then addr0 -> D_OUT=3 one edge after the first read, 6 one edge after the second.
REQ-032 Hold: after reading 6, drop EN_RD and write addr0=9 -> D_OUT stays 6 until the next read, which returns 9.
REQ-033 Collision: mem[1]=3; on the same edge write addr1=5 and read addr1 -> D_OUT=5 with the macro, 3 without it; the following read returns 5.
REQ-034 Async reset mid-run: assert RST_N between edges with D_OUT=6 -> D_OUT=0 immediately; a later read of addr0 returns 0.
REQ-035 Out of range: with DEPTH=3 and ADDR_WIDTH=2, write addr3=7, then read addr3 -> D_OUT=0; words 0 to 2 are unchanged.
